// File: rtl/key_conditioner_pkg.sv
// key_pkg: constants shared by the key conditioner files.
// Holds default sizing and the counter width helper.
package key_pkg;

   localparam int NUM_KEYS_DEFAULT        = 4;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 8;

   // Wide enough to hold DEBOUNCE_CYCLES itself.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

   // Per-channel view of the debounced outputs.
   typedef struct packed {
      logic level;
      logic press;
      logic rel;
   } key_evt_t;

endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw board keys in, debounced levels and strobes out.
// master = board/FSM side, slave = conditioner side.
interface key_conditioner_if
   import key_pkg::*;
#(
   parameter int NUM_KEYS = NUM_KEYS_DEFAULT
);

   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] pressed;
   logic [NUM_KEYS-1:0] press_pulse;
   logic [NUM_KEYS-1:0] release_pulse;

   modport master (
      output key_n,
      input  pressed,
      input  press_pulse,
      input  release_pulse
   );

   modport slave (
      input  key_n,
      output pressed,
      output press_pulse,
      output release_pulse
   );

endinterface

// File: rtl/key_conditioner_debounce.sv
// key_debounce: one key channel -- synchronizer, debounce counter,
// stable level and one-cycle press/release strobes.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n_i,
   output logic pressed_o,
   output logic press_pulse_o,
   output logic release_pulse_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   key_evt_t      evt_q;
   key_evt_t      evt_d;
   logic          raw_sync;
   logic          mismatch;
   logic          accept;

   // Two-flop synchronizer; idles at released (1) out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

   assign raw_sync = ~sync2_q;
   assign mismatch = (raw_sync != stable_q);
   assign accept   = mismatch && (cnt_q == CNT_LAST);

   // Count consecutive disagreements; any agreement drops all progress.
   always_comb begin
      stable_d    = stable_q;
      cnt_d       = '0;
      evt_d.press = 1'b0;
      evt_d.rel   = 1'b0;
      if (accept) begin
         stable_d    = ~stable_q;
         evt_d.press = ~stable_q;
         evt_d.rel   = stable_q;
      end else if (mismatch) begin
         cnt_d = cnt_q + 1'b1;
      end
      evt_d.level = stable_d;
   end

   // Debounce state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         evt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         evt_q    <= evt_d;
      end
   end

   assign pressed_o       = evt_q.level;
   assign press_pulse_o   = evt_q.press;
   assign release_pulse_o = evt_q.rel;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS independent debounced key channels.
// No clock division here; runs directly on clk.
module key_conditioner
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   key_conditioner_if.slave   kif
);

   logic [NUM_KEYS-1:0] pressed_w;
   logic [NUM_KEYS-1:0] press_w;
   logic [NUM_KEYS-1:0] rel_w;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk             (clk),
         .reset           (reset),
         .key_n_i         (kif.key_n[i]),
         .pressed_o       (pressed_w[i]),
         .press_pulse_o   (press_w[i]),
         .release_pulse_o (rel_w[i])
      );
   end

   assign kif.pressed       = pressed_w;
   assign kif.press_pulse   = press_w;
   assign kif.release_pulse = rel_w;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed vector table, reset corner sequences
// and a random bounce run against a small reference model.
module tb_key_conditioner;

   localparam int NK = 4;
   localparam int D  = 8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   key_conditioner_if #(.NUM_KEYS(NK)) kif ();

   key_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kif   (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NK-1:0] kn;
      int            n;
      logic [NK-1:0] ep;
      logic [NK-1:0] epp;
      logic [NK-1:0] erp;
   } vec_t;

   vec_t tbl [22];

   // Reference model: synchronizer plus run-length of disagreement.
   logic [NK-1:0] m_s1;
   logic [NK-1:0] m_s2;
   logic [NK-1:0] m_stab;
   logic [NK-1:0] m_press;
   logic [NK-1:0] m_rel;
   int            m_run [NK];

   always @(posedge clk) begin
      if (reset) begin
         m_s1    <= '1;
         m_s2    <= '1;
         m_stab  <= '0;
         m_press <= '0;
         m_rel   <= '0;
         for (int i = 0; i < NK; i++) m_run[i] <= 0;
      end else begin
         m_s1 <= kif.key_n;
         m_s2 <= m_s1;
         for (int i = 0; i < NK; i++) begin
            m_press[i] <= 1'b0;
            m_rel[i]   <= 1'b0;
            if (~m_s2[i] == m_stab[i]) begin
               m_run[i] <= 0;
            end else if (m_run[i] + 1 >= D) begin
               m_run[i]   <= 0;
               m_stab[i]  <= ~m_stab[i];
               m_press[i] <= ~m_stab[i];
               m_rel[i]   <= m_stab[i];
            end else begin
               m_run[i] <= m_run[i] + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [NK-1:0] ep,
                        input logic [NK-1:0] epp,
                        input logic [NK-1:0] erp);
      checks++;
      if (kif.pressed !== ep || kif.press_pulse !== epp ||
          kif.release_pulse !== erp) begin
         errors++;
         $display("FAIL %s: got pressed=%b press=%b rel=%b want pressed=%b press=%b rel=%b",
                  name, kif.pressed, kif.press_pulse, kif.release_pulse,
                  ep, epp, erp);
      end
   endtask

   initial begin
      logic [NK-1:0] prev;
      int            hold [NK];
      logic [NK-1:0] kn;

      checks = 0;
      errors = 0;

      tbl[0]  = '{4'b1110,  9, 4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b1110,  1, 4'b0001, 4'b0001, 4'b0000};
      tbl[2]  = '{4'b1110,  1, 4'b0001, 4'b0000, 4'b0000};
      tbl[3]  = '{4'b1111,  9, 4'b0001, 4'b0000, 4'b0000};
      tbl[4]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0001};
      tbl[5]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000};
      tbl[6]  = '{4'b1101,  5, 4'b0000, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000};
      tbl[8]  = '{4'b1101,  5, 4'b0000, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b1101,  4, 4'b0000, 4'b0000, 4'b0000};
      tbl[10] = '{4'b1101,  1, 4'b0010, 4'b0010, 4'b0000};
      tbl[11] = '{4'b1101,  1, 4'b0010, 4'b0000, 4'b0000};
      tbl[12] = '{4'b1111, 12, 4'b0000, 4'b0000, 4'b0000};
      tbl[13] = '{4'b1011, 10, 4'b0100, 4'b0100, 4'b0000};
      tbl[14] = '{4'b1011,  1, 4'b0100, 4'b0000, 4'b0000};
      tbl[15] = '{4'b0111,  3, 4'b0100, 4'b0000, 4'b0000};
      tbl[16] = '{4'b1111,  3, 4'b0100, 4'b0000, 4'b0000};
      tbl[17] = '{4'b0111,  3, 4'b0100, 4'b0000, 4'b0000};
      tbl[18] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0100};
      tbl[19] = '{4'b0111,  3, 4'b0000, 4'b0000, 4'b0000};
      tbl[20] = '{4'b1111,  3, 4'b0000, 4'b0000, 4'b0000};
      tbl[21] = '{4'b1111, 12, 4'b0000, 4'b0000, 4'b0000};

      reset     = 1'b1;
      kif.key_n = '1;
      repeat (3) tick();
      check("reset_state", 4'b0000, 4'b0000, 4'b0000);

      reset = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         check("idle_50", 4'b0000, 4'b0000, 4'b0000);
      end

      for (int r = 0; r < 22; r++) begin
         kif.key_n = tbl[r].kn;
         repeat (tbl[r].n) tick();
         check($sformatf("vec%0d", r), tbl[r].ep, tbl[r].epp, tbl[r].erp);
      end

      kif.key_n = 4'b1110;
      for (int c = 0; c < 6; c++) begin
         tick();
         check("pre_reset", 4'b0000, 4'b0000, 4'b0000);
      end
      reset = 1'b1;
      tick();
      check("mid_deb_reset", 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b0;
      for (int j = 1; j <= D + 4; j++) begin
         tick();
         check($sformatf("post_reset_e%0d", j),
               (j >= D + 2) ? 4'b0001 : 4'b0000,
               (j == D + 2) ? 4'b0001 : 4'b0000,
               4'b0000);
      end

      reset     = 1'b1;
      kif.key_n = 4'b1111;
      tick();
      check("reset_held", 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         check("after_reset_idle", 4'b0000, 4'b0000, 4'b0000);
      end

      for (int i = 0; i < NK; i++) hold[i] = 0;
      kn   = kif.key_n;
      prev = kif.pressed;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NK; i++) begin
            if (hold[i] == 0) begin
               kn[i]   = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 12);
            end
            hold[i]--;
         end
         kif.key_n = kn;
         tick();
         check("rand_model", m_stab, m_press, m_rel);
         checks++;
         if ((kif.press_pulse & kif.release_pulse) != '0 ||
             kif.press_pulse != (kif.pressed & ~prev) ||
             kif.release_pulse != (~kif.pressed & prev)) begin
            errors++;
            $display("FAIL rand_edge: cycle %0d pressed=%b prev=%b press=%b rel=%b",
                     c, kif.pressed, prev, kif.press_pulse, kif.release_pulse);
         end
         prev = kif.pressed;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter: NUM_KEYS, default 4, number of independent key channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 8, consecutive stable clk cycles needed to accept a level change (legal 2..2^20).
REQ-003 Port: clk  input  1  single clock for all state; the block has exactly one clock, and reset is synchronous and active-high.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port: key_n  input  NUM_KEYS  raw board keys, asynchronous, active-low (0 = pressed).
REQ-006 Port: pressed  output  NUM_KEYS  debounced level, active-high (1 = held).
REQ-007 Port: press_pulse  output  NUM_KEYS  one-cycle strobe on accepted press.
REQ-008 Port: release_pulse  output  NUM_KEYS  one-cycle strobe on accepted release.

Function
REQ-009 Each channel SHALL be processed independently; no cross-channel interaction.
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic; no other logic reads key_n directly.
REQ-011 Synchronized value SHALL be inverted to active-high (raw_sync = ~key_n after 2 flops).
REQ-012 Each channel SHALL hold a stable state (drives pressed) and a saturating counter of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-013 Cycle where raw_sync == stable: counter SHALL clear to 0.
REQ-014 Cycle where raw_sync != stable: counter SHALL increment; on the edge where it would reach DEBOUNCE_CYCLES, stable SHALL toggle and counter SHALL clear to 0.
REQ-015 Any glitch (raw_sync returning to stable) before DEBOUNCE_CYCLES consecutive mismatches SHALL discard progress; no partial credit.
REQ-016 Latency: a key_n change first sampled at edge k SHALL appear on pressed after edge k+1+DEBOUNCE_CYCLES, if held stable throughout.
REQ-017 press_pulse[i] SHALL be 1 for exactly the one cycle following the edge where stable[i] goes 0->1; release_pulse[i] likewise for 1->0.
REQ-018 press_pulse and release_pulse for a channel SHALL never be 1 in the same cycle.
REQ-019 All outputs SHALL be registered; no combinational path from key_n to any output.
REQ-020 Counter SHALL never wrap; maximum value reached is DEBOUNCE_CYCLES-1 before toggle.

Reset
REQ-021 On reset: synchronizer flops SHALL load 1 (released), stable 0, counters 0, pressed 0, press_pulse 0, release_pulse 0.
REQ-022 Reset asserted mid-debounce SHALL abort the count; no pulse SHALL issue in the cycle following reset.
REQ-023 A key held through reset release SHALL be treated as a new press: press_pulse after DEBOUNCE_CYCLES+2 edges post-reset.

Structure
REQ-024 Shared package key_pkg SHALL hold NUM_KEYS_DEFAULT (4) and DEBOUNCE_CYCLES_DEFAULT (8) constants.
REQ-025 One sub-module key_debounce (single channel: synchronizer, counter, stable, pulses) SHALL exist; key_conditioner SHALL instantiate NUM_KEYS copies via generate.
REQ-026 Top-level board integration SHALL connect key_n to KEY and pressed/pulses to FSM inputs; the block itself SHALL NOT include clock dividing.

Verification
REQ-027 Reset, key_n=4'b1111 held 50 cycles -> pressed=0, no pulses ever.
REQ-028 DEBOUNCE_CYCLES=8; key_n[0] 1->0 sampled at edge 10, held -> pressed[0]=1 after edge 19, press_pulse[0]=1 for cycle after edge 19 only.
REQ-029 key_n[1] low for 5 cycles, high 1 cycle, low 5 cycles (bounce) -> pressed[1] stays 0, no pulse; then held low 8+ cycles -> single press_pulse.
REQ-030 Key 2 held pressed then released for 8+ cycles -> single release_pulse[2], pressed[2] falls same cycle; key 3 toggled concurrently unaffected.
REQ-031 key_n[0]=0 for 6 cycles, reset pulsed 1 cycle, key held -> no pulse before reset, press_pulse[0] exactly DEBOUNCE_CYCLES+2 edges after reset deasserts.
REQ-032 Random key_n bounce on all 4 channels, 10k cycles -> scoreboard: pulses match stable transitions, never press+release same cycle, counter < DEBOUNCE_CYCLES.
